// File: rtl/lcd_display_char_writer.sv
// Avalon-MM write slave: queues CPU bytes in a FIFO and paces them onto an HD44780 8-bit LCD bus.
// Optional build macro LCD_WRITER_IRQ_EN adds an irq output raised when the queue drains.
module lcd_display_char_writer #(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4,
    parameter int SETUP_CYC  = 3,
    parameter int PULSE_CYC  = 12,
    parameter int HOLD_CYC   = 2,
    parameter int EXEC_CYC   = 2000,
    parameter int CLR_CYC    = 82000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        lcd_e,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic [7:0]  lcd_data
`ifdef LCD_WRITER_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_B   = (HOLD_CYC > EXEC_CYC) ? HOLD_CYC : EXEC_CYC;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CYC = (MAX_C > CLR_CYC) ? MAX_C : CLR_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0]   CYC_ONE = CNT_W'(1);
    localparam logic [FIFO_AW:0]   LVL_ONE = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT} state_t;

    state_t             r_state, w_next_state;
    logic [CNT_W-1:0]   r_cnt, w_cnt_load;
    logic               w_cnt_done, w_pop;
    logic [8:0]         r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [FIFO_AW:0]   r_count, w_count_next;
    logic               w_wr, w_push, w_ctrl_wr, w_flush;
    logic               w_full, w_empty, w_push_ok, w_push_drop, w_busy;
    logic               r_ovf, r_irq_en, w_irq_pend;
    logic               w_unused;

    assign w_wr        = chipselect & ~write_n;
    assign w_push      = w_wr & ~address[1];
    assign w_ctrl_wr   = w_wr & (address == 2'd2);
    assign w_flush     = w_ctrl_wr & writedata[1];
    assign w_full      = (r_count == LVL_FULL);
    assign w_empty     = (r_count == '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_push_ok   = w_push & ~w_flush & (~w_full | w_pop);
    assign w_push_drop = w_push & ~w_flush & w_full & ~w_pop;
    assign w_busy      = (r_state != S_IDLE) | ~w_empty;
    assign w_cnt_done  = (r_cnt == '0);
    assign lcd_rw      = 1'b0;
    assign w_unused    = ^writedata[31:8];

    always_comb begin
        w_count_next = r_count;
        if (w_flush)
            w_count_next = '0;
        else if (w_push_ok && !w_pop)
            w_count_next = r_count + LVL_ONE;
        else if (!w_push_ok && w_pop)
            w_count_next = r_count - LVL_ONE;
    end

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= {(address == 2'd0), writedata[7:0]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE:  if (!w_empty) begin
                         w_pop        = 1'b1;
                         w_next_state = S_SETUP;
                     end
            S_SETUP: if (w_cnt_done) w_next_state = S_PULSE;
            S_PULSE: if (w_cnt_done) w_next_state = S_HOLD;
            S_HOLD:  if (w_cnt_done) w_next_state = S_WAIT;
            S_WAIT:  if (w_cnt_done) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_load = '0;
        case (w_next_state)
            S_SETUP: w_cnt_load = CNT_W'(SETUP_CYC - 1);
            S_PULSE: w_cnt_load = CNT_W'(PULSE_CYC - 1);
            S_HOLD:  w_cnt_load = CNT_W'(HOLD_CYC - 1);
            S_WAIT:  w_cnt_load = (!lcd_rs && (lcd_data == 8'h01 || lcd_data == 8'h02))
                                  ? CNT_W'(CLR_CYC - 1) : CNT_W'(EXEC_CYC - 1);
            default: w_cnt_load = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // Counter reloads on every state change, so each state lasts exactly its parameter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= '0;
        end else begin
            if (r_state != w_next_state)
                r_cnt <= w_cnt_load;
            else if (!w_cnt_done)
                r_cnt <= r_cnt - CYC_ONE;
            lcd_e <= (w_next_state == S_PULSE);
            if (w_pop)
                {lcd_rs, lcd_data} <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf    <= 1'b0;
            r_irq_en <= 1'b0;
        end else begin
            if (w_push_drop)
                r_ovf <= 1'b1;
            else if (w_ctrl_wr && writedata[2])
                r_ovf <= 1'b0;
            if (w_ctrl_wr)
                r_irq_en <= writedata[0];
        end
    end

`ifdef LCD_WRITER_IRQ_EN
    logic r_irq_pend;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_irq_pend <= 1'b0;
        else if (w_push || (w_ctrl_wr && !writedata[0]))
            r_irq_pend <= 1'b0;
        else if (r_state == S_WAIT && w_cnt_done && w_count_next == '0)
            r_irq_pend <= 1'b1;
    end

    assign w_irq_pend = r_irq_pend;
    assign irq        = r_irq_pend & r_irq_en;
`else
    assign w_irq_pend = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata <= '0;
        else begin
            case (address)
                2'd0:    readdata <= {27'd0, w_irq_pend, r_ovf, w_full, w_empty, w_busy};
                2'd1:    readdata <= {{(31 - FIFO_AW){1'b0}}, r_count};
                2'd2:    readdata <= {31'd0, r_irq_en};
                default: readdata <= '0;
            endcase
        end
    end
endmodule
